// File: rtl/updown_counter_synchronous_pkg.sv
// Purpose: shared constants, operation encoding and decode helper for the up/down counter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package updown_counter_pkg;

    // Width used when a parent does not override it.
    localparam int DEFAULT_WIDTH = 8;

    // Meaning of the mode input.
    localparam logic MODE_UP   = 1'b1;
    localparam logic MODE_DOWN = 1'b0;

    // The four things the counter can do on an edge, highest priority first.
    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_LOAD  = 2'd1,
        OP_UP    = 2'd2,
        OP_DOWN  = 2'd3
    } op_e;

    // Priority decode of the control inputs. if-statement semantics mean an
    // X/Z on clr or ld falls through as inactive instead of poisoning count.
    function automatic op_e decode_op(input logic clr, input logic ld, input logic mode);
        op_e op;
        if (clr) begin
            op = OP_CLEAR;
        end else if (ld) begin
            op = OP_LOAD;
        end else if (mode == MODE_UP) begin
            op = OP_UP;
        end else begin
            op = OP_DOWN;
        end
        return op;
    endfunction

endpackage

// File: rtl/updown_counter_synchronous_if.sv
// Purpose: control/data bundle between a counter user and the counter.
// Latency: n/a (wiring only).
// Backpressure: none; the counter accepts controls every cycle.
interface updown_counter_synchronous_if
    import updown_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             clr;
    logic             ld;
    logic             mode;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] count;
    logic             tc;

    // Side that drives the controls and observes the count.
    modport master (
        output clr,
        output ld,
        output mode,
        output din,
        input  count,
        input  tc
    );

    // The counter itself.
    modport slave (
        input  clr,
        input  ld,
        input  mode,
        input  din,
        output count,
        output tc
    );

endinterface

// File: rtl/updown_counter_synchronous_next.sv
// Purpose: combinational next-count mux (clear > load > up > down).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
module updown_counter_next
    import updown_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clr,
    input  logic             ld,
    input  logic             mode,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_nxt
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    op_e op;

    // Resolve which operation wins this edge.
    always_comb begin
        op = decode_op(clr, ld, mode);
    end

    // Select the next value; +/- wrap naturally because the carry/borrow is dropped.
    always_comb begin
        count_nxt = count;
        unique case (op)
            OP_CLEAR: count_nxt = '0;
            OP_LOAD:  count_nxt = din;
            OP_UP:    count_nxt = count + ONE;
            OP_DOWN:  count_nxt = count - ONE;
            default:  count_nxt = count;
        endcase
    end

endmodule

// File: rtl/updown_counter_synchronous.sv
// Purpose: loadable, clearable up/down binary counter with combinational terminal count.
// Latency: 1 cycle from control/din sampling to count update; tc follows count/mode directly.
// Backpressure: none; advances on every edge unless cleared or loaded.
module updown_counter_synchronous
    import updown_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    updown_counter_synchronous_if.slave bus
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_nxt;

    updown_counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .clr       (bus.clr),
        .ld        (bus.ld),
        .mode      (bus.mode),
        .din       (bus.din),
        .count     (count_q),
        .count_nxt (count_nxt)
    );

    // Count register: async reset to zero, otherwise take the muxed next value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_nxt;
        end
    end

    assign bus.count = count_q;

    // Terminal count flags the value just before a wrap in the current direction.
    assign bus.tc = ((bus.mode == MODE_UP)   && (count_q == ALL_ONES)) ||
                    ((bus.mode == MODE_DOWN) && (count_q == '0));

endmodule

// File: tb/tb_updown_counter_synchronous.sv
module tb_updown_counter_synchronous;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;

    updown_counter_synchronous_if #(.WIDTH(8)) bus ();

    updown_counter_synchronous #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic c, input logic l, input logic m, input logic [7:0] d);
        bus.clr = c; bus.ld = l; bus.mode = m; bus.din = d;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
        n_vec = n_vec + 1;
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        #1;
        n_vec = n_vec + 1;
        if (bus.count !== 8'h00 || bus.tc !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_state: count=%02h tc=%b", bus.count, bus.tc);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;

        drive(1'b0, 1'b1, 1'b1, 8'h01);
        edges(1);
        if (bus.count !== 8'h01 || bus.tc !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL load_01: count=%02h tc=%b", bus.count, bus.tc);
        end

        drive(1'b0, 1'b0, 1'b1, 8'h00);
        edges(25);
        if (bus.count !== 8'h1A) begin
            n_fail = n_fail + 1;
            $display("FAIL up_25: count=%02h", bus.count);
        end

        drive(1'b0, 1'b0, 1'b0, 8'h00);
        edges(20);
        if (bus.count !== 8'h06) begin
            n_fail = n_fail + 1;
            $display("FAIL down_20: count=%02h", bus.count);
        end

        drive(1'b1, 1'b0, 1'b0, 8'h00);
        edges(1);
        if (bus.count !== 8'h00 || bus.tc !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL clear: count=%02h tc=%b", bus.count, bus.tc);
        end

        drive(1'b0, 1'b0, 1'b1, 8'h00);
        edges(10);
        if (bus.count !== 8'h0A) begin
            n_fail = n_fail + 1;
            $display("FAIL up_10: count=%02h", bus.count);
        end

        drive(1'b0, 1'b1, 1'b1, 8'hFF);
        edges(1);
        if (bus.count !== 8'hFF || bus.tc !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL load_ff_tc: count=%02h tc=%b", bus.count, bus.tc);
        end

        drive(1'b0, 1'b0, 1'b1, 8'h00);
        edges(1);
        if (bus.count !== 8'h00 || bus.tc !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL wrap_up: count=%02h tc=%b", bus.count, bus.tc);
        end

        drive(1'b0, 1'b1, 1'b0, 8'h00);
        edges(1);
        if (bus.count !== 8'h00 || bus.tc !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL load_00_tc: count=%02h tc=%b", bus.count, bus.tc);
        end

        drive(1'b0, 1'b0, 1'b0, 8'h00);
        edges(1);
        if (bus.count !== 8'hFF || bus.tc !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL wrap_down: count=%02h tc=%b", bus.count, bus.tc);
        end

        drive(1'b1, 1'b1, 1'b1, 8'h55);
        edges(1);
        if (bus.count !== 8'h00 || bus.tc !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL clr_beats_ld: count=%02h tc=%b", bus.count, bus.tc);
        end

        drive(1'b0, 1'b1, 1'b1, 8'h55);
        edges(1);
        if (bus.count !== 8'h55) begin
            n_fail = n_fail + 1;
            $display("FAIL load_55: count=%02h", bus.count);
        end

        drive(1'b0, 1'b1, 1'b0, 8'h10);
        edges(1);
        if (bus.count !== 8'h10 || bus.tc !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL ld_beats_mode: count=%02h tc=%b", bus.count, bus.tc);
        end

        drive(1'b0, 1'b0, 1'b0, 8'h10);
        edges(1);
        if (bus.count !== 8'h0F) begin
            n_fail = n_fail + 1;
            $display("FAIL mode_next_edge: count=%02h", bus.count);
        end

        drive(1'bx, 1'b0, 1'b1, 8'hAA);
        edges(1);
        if (bus.count !== 8'h10) begin
            n_fail = n_fail + 1;
            $display("FAIL clr_x_inactive: count=%02h", bus.count);
        end

        drive(1'b0, 1'bx, 1'b1, 8'hAA);
        edges(1);
        if (bus.count !== 8'h11) begin
            n_fail = n_fail + 1;
            $display("FAIL ld_x_inactive: count=%02h", bus.count);
        end

        drive(1'b0, 1'b0, 1'b1, 8'h00);
        edges(2);
        if (bus.count !== 8'h13) begin
            n_fail = n_fail + 1;
            $display("FAIL up_2: count=%02h", bus.count);
        end

        drive(1'b0, 1'b1, 1'b1, 8'h37);
        edges(1);
        if (bus.count !== 8'h37) begin
            n_fail = n_fail + 1;
            $display("FAIL load_37: count=%02h", bus.count);
        end

        #2 rst_n = 1'b0;
        #1;
        n_vec = n_vec + 1;
        if (bus.count !== 8'h00 || bus.tc !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL async_reset: count=%02h tc=%b", bus.count, bus.tc);
        end

        edges(1);
        if (bus.count !== 8'h00) begin
            n_fail = n_fail + 1;
            $display("FAIL held_in_reset: count=%02h", bus.count);
        end

        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        edges(1);
        if (bus.count !== 8'h01 || bus.tc !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL resume_from_0: count=%02h tc=%b", bus.count, bus.tc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
